conv_seq_ctrl: RTL and testbench

// - Layer sequencer for conv_unit: latches one layer descriptor, clears both strided buffers, then streams

---
 rtl/conv_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: layer sequencer for conv_unit.
// Latches a layer descriptor, clears the weight/kernel buffers, streams weight and
// kernel beats from the DDR read stream into them, then issues one compute
// instruction per output pixel and pulses done.
// Optional feature: define CONV_SEQ_CTRL_PERF_EN to build the stall counter;
// without it perf_stall_cnt is tied to zero.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; descriptor register holds the last layer
// S_PARA    | descriptor write strobe to conv_unit; beat/inst counts derived
// S_CLR     | one-cycle clear of both buffers
// S_LOAD_WB | accepting n_wb weight beats
// S_LOAD_KB | accepting n_kb kernel beats
// S_ISSUE   | issuing n_inst instructions, last one tagged op=2'b11
// S_FIN     | one-cycle done pulse
module conv_seq_ctrl #(
  parameter int B_LAYERPARA  = 80,
  parameter int B_INST       = 32,
  parameter int B_CNT        = 32,
  parameter int PIX_PER_BEAT = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [B_LAYERPARA-1:0] layer_para_i,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  output logic [B_LAYERPARA-1:0] layer_para,
  output logic                   layer_para_we,
  output logic                   wb_clr,
  output logic                   kb_clr,
  output logic                   wb_en,
  output logic                   kb_en,
  output logic [B_INST-1:0]      inst_o,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic                   busy,
  output logic                   done,
  output logic [B_CNT-1:0]       perf_stall_cnt
);

  localparam int SH = $clog2(PIX_PER_BEAT);

  typedef enum logic [2:0] {
    S_IDLE, S_PARA, S_CLR, S_LOAD_WB, S_LOAD_KB, S_ISSUE, S_FIN
  } state_e;

  state_e                 state_q, state_d;
  logic [B_LAYERPARA-1:0] para_q, para_d;
  logic [B_CNT-1:0]       n_wb_q, n_wb_d;
  logic [B_CNT-1:0]       n_kb_q, n_kb_d;
  logic [B_CNT-1:0]       n_inst_q, n_inst_d;
  // Remaining beats/instructions in the current phase; terminal count is 1.
  logic [B_CNT-1:0]       rem_q, rem_d;
  logic                   abort_clr_q, abort_clr_d;

  logic [B_CNT-1:0] c_wei_s, h_wei, w_wei, c_ker_s, k_ker;
  logic [B_CNT-1:0] n_wb_calc, n_kb_calc, n_inst_calc;
  state_e           after_wb_state, after_kb_state;
  logic [B_CNT-1:0] after_wb_rem, after_kb_rem;
  logic [29:0]      idx;
  logic [1:0]       op;

  // Channel counts are in pixels; one memory beat carries PIX_PER_BEAT of them.
  assign c_wei_s     = B_CNT'(para_q[15:0] >> SH);
  assign h_wei       = B_CNT'(para_q[31:16]);
  assign w_wei       = B_CNT'(para_q[47:32]);
  assign c_ker_s     = B_CNT'(para_q[63:48] >> SH);
  assign k_ker       = B_CNT'(para_q[79:64]);
  assign n_wb_calc   = c_wei_s * h_wei * w_wei;
  assign n_kb_calc   = c_ker_s * k_ker * k_ker;
  assign n_inst_calc = h_wei * w_wei;

  // Phase after the kernel load: issue if there is anything to issue, else finish.
  always_comb begin
    after_kb_state = S_FIN;
    after_kb_rem   = '0;
    if (n_inst_q != '0) begin
      after_kb_state = S_ISSUE;
      after_kb_rem   = n_inst_q;
    end
  end

  // Phase after the weight load: empty kernel loads are skipped entirely.
  always_comb begin
    after_wb_state = after_kb_state;
    after_wb_rem   = after_kb_rem;
    if (n_kb_q != '0) begin
      after_wb_state = S_LOAD_KB;
      after_wb_rem   = n_kb_q;
    end
  end

  assign idx = 30'(n_inst_q - rem_q);
  assign op  = (rem_q == B_CNT'(1)) ? 2'b11 : 2'b01;

  // Next-state, counter and output decode.
  always_comb begin
    state_d       = state_q;
    para_d        = para_q;
    n_wb_d        = n_wb_q;
    n_kb_d        = n_kb_q;
    n_inst_d      = n_inst_q;
    rem_d         = rem_q;
    abort_clr_d   = 1'b0;
    mem_ready     = 1'b0;
    wb_en         = 1'b0;
    kb_en         = 1'b0;
    layer_para_we = 1'b0;
    inst_valid    = 1'b0;
    inst_o        = '0;
    done          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_PARA;
          para_d  = layer_para_i;
        end
      end
      S_PARA: begin
        layer_para_we = 1'b1;
        n_wb_d        = n_wb_calc;
        n_kb_d        = n_kb_calc;
        n_inst_d      = n_inst_calc;
        state_d       = S_CLR;
      end
      S_CLR: begin
        if (n_wb_q != '0) begin
          state_d = S_LOAD_WB;
          rem_d   = n_wb_q;
        end else begin
          state_d = after_wb_state;
          rem_d   = after_wb_rem;
        end
      end
      S_LOAD_WB: begin
        mem_ready = 1'b1;
        wb_en     = mem_valid;
        if (mem_valid) begin
          rem_d = rem_q - B_CNT'(1);
          if (rem_q == B_CNT'(1)) begin
            state_d = after_wb_state;
            rem_d   = after_wb_rem;
          end
        end
      end
      S_LOAD_KB: begin
        mem_ready = 1'b1;
        kb_en     = mem_valid;
        if (mem_valid) begin
          rem_d = rem_q - B_CNT'(1);
          if (rem_q == B_CNT'(1)) begin
            state_d = after_kb_state;
            rem_d   = after_kb_rem;
          end
        end
      end
      S_ISSUE: begin
        inst_valid = 1'b1;
        inst_o     = B_INST'({op, idx});
        if (inst_ready) begin
          rem_d = rem_q - B_CNT'(1);
          if (rem_q == B_CNT'(1)) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops whatever is in flight; the buffers get cleared on the way out.
    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      rem_d       = '0;
      n_wb_d      = '0;
      n_kb_d      = '0;
      n_inst_d    = '0;
      abort_clr_d = 1'b1;
      mem_ready   = 1'b0;
      wb_en       = 1'b0;
      kb_en       = 1'b0;
      done        = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      para_q      <= '0;
      n_wb_q      <= '0;
      n_kb_q      <= '0;
      n_inst_q    <= '0;
      rem_q       <= '0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      para_q      <= para_d;
      n_wb_q      <= n_wb_d;
      n_kb_q      <= n_kb_d;
      n_inst_q    <= n_inst_d;
      rem_q       <= rem_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  assign wb_clr     = (state_q == S_CLR) || abort_clr_q;
  assign kb_clr     = wb_clr;
  assign busy       = (state_q != S_IDLE);
  assign layer_para = para_q;

`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [B_CNT-1:0] perf_q, perf_d;
  logic             stall;

  assign stall = ((state_q == S_LOAD_WB || state_q == S_LOAD_KB) && !mem_valid) ||
                 ((state_q == S_ISSUE) && !inst_ready);

  // Stall count restarts with each layer and sticks at all-ones.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start && !abort) begin
      perf_d = '0;
    end else if (stall && perf_q != '1) begin
      perf_d = perf_q + B_CNT'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: table of layers run through a monitor/scoreboard,
// plus hand sequences for reset, abort, ignored starts and mid-run reset.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [79:0] layer_para_i = '0;
  logic        mem_valid = 1'b0;
  logic        inst_ready = 1'b0;
  logic        mem_ready, layer_para_we, wb_clr, kb_clr, wb_en, kb_en;
  logic        inst_valid, busy, done;
  logic [79:0] layer_para;
  logic [31:0] inst_o;
  logic [31:0] perf_stall_cnt;

  conv_seq_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .layer_para_i(layer_para_i), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .layer_para(layer_para), .layer_para_we(layer_para_we),
    .wb_clr(wb_clr), .kb_clr(kb_clr), .wb_en(wb_en), .kb_en(kb_en),
    .inst_o(inst_o), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] c_wei, h, w, c_ker, k;
    int          n_wb, n_kb, n_inst;
    bit          toggle, stall, poke;
  } row_t;

  row_t rows[7];

  // Monitor / scoreboard state
  int          wb_cnt, kb_cnt, inst_cnt, done_cnt, we_cnt, clr_cnt, viol, stall_obs;
  int          we_cyc, clr_cyc, iv_cyc, done_cyc;
  logic        hold_q = 1'b0;
  logic [31:0] hold_inst = '0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rstn) begin
      hold_q = 1'b0;
    end else begin
      if (wb_en) wb_cnt++;
      if (kb_en) kb_cnt++;
      if (wb_en && kb_en) viol++;
      if ((wb_en || kb_en) && !(mem_valid && mem_ready)) viol++;
      if (mem_ready && !busy) viol++;
      if (wb_clr != kb_clr) viol++;
      if (layer_para_we) begin we_cnt++; we_cyc = cyc; end
      if (wb_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (inst_valid && iv_cyc < 0) iv_cyc = cyc;
      if (hold_q && (!inst_valid || inst_o != hold_inst)) viol++;
      hold_q = inst_valid && !inst_ready;
      hold_inst = inst_o;
      if ((mem_ready && !mem_valid) || (inst_valid && !inst_ready)) stall_obs++;
      if (inst_valid && inst_ready) begin
        inst_cnt++;
        if (exp_q.size() == 0) begin
          check("inst_unexpected", 80'(inst_o), 80'(0));
        end else begin
          e = exp_q.pop_front();
          check("inst_word", 80'(inst_o), 80'(e));
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic clear_mon();
    wb_cnt = 0; kb_cnt = 0; inst_cnt = 0; done_cnt = 0; we_cnt = 0; clr_cnt = 0;
    viol = 0; stall_obs = 0; we_cyc = -1; clr_cyc = -1; iv_cyc = -1; done_cyc = -1;
    exp_q.delete();
  endtask

  task automatic run_row(input row_t r, input string tag);
    logic [79:0] desc;
    logic [31:0] w;
    logic [1:0]  op;
    int start_cyc, stall_left;
    bit got, poked;
    clear_mon();
    for (int i = 0; i < r.n_inst; i++) begin
      op = (i == r.n_inst - 1) ? 2'b11 : 2'b01;
      w = {op, i[29:0]};
      exp_q.push_back(w);
    end
    desc = {r.k, r.c_ker, r.w, r.h, r.c_wei};
    @(posedge clk); #1;
    layer_para_i = desc;
    start = 1'b1;
    start_cyc = cyc;
    mem_valid = 1'b1;
    inst_ready = 1'b1;
    stall_left = 3;
    got = 0;
    poked = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1;
      if (!got) begin
        @(posedge clk); #1;
        start = 1'b0;
        mem_valid = r.toggle ? cyc[0] : 1'b1;
        if (r.stall && inst_valid && inst_o[29:0] == 30'd2 && stall_left > 0) begin
          inst_ready = 1'b0;
          stall_left--;
        end else begin
          inst_ready = 1'b1;
        end
        if (r.poke && !poked && inst_valid) begin
          start = 1'b1;
          layer_para_i = ~desc;
          poked = 1;
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    mem_valid = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    check({tag, " done_seen"}, 80'(got), 80'(1));
    check({tag, " done_pulses"}, 80'(done_cnt), 80'(1));
    check({tag, " wb_beats"}, 80'(wb_cnt), 80'(r.n_wb));
    check({tag, " kb_beats"}, 80'(kb_cnt), 80'(r.n_kb));
    check({tag, " insts"}, 80'(inst_cnt), 80'(r.n_inst));
    check({tag, " inst_left"}, 80'(exp_q.size()), 80'(0));
    check({tag, " protocol_viol"}, 80'(viol), 80'(0));
    check({tag, " we_cycle"}, 80'(we_cyc - start_cyc), 80'(1));
    check({tag, " clr_cycle"}, 80'(clr_cyc - start_cyc), 80'(2));
    check({tag, " clr_pulses"}, 80'(clr_cnt), 80'(1));
    check({tag, " layer_para"}, layer_para, desc);
    if (!r.toggle && !r.stall)
      check({tag, " latency"}, 80'(done_cyc - start_cyc), 80'(3 + r.n_wb + r.n_kb + r.n_inst));
    if (!r.toggle && r.n_inst > 0)
      check({tag, " issue_entry"}, 80'(iv_cyc - start_cyc), 80'(3 + r.n_wb + r.n_kb));
`ifdef CONV_SEQ_CTRL_PERF_EN
    check({tag, " perf"}, 80'(perf_stall_cnt), 80'(stall_obs));
`else
    check({tag, " perf"}, 80'(perf_stall_cnt), 80'(0));
`endif
  endtask

  initial begin
    int beats;
    logic [79:0] last_desc;

    rows[0] = '{16'd8, 16'd2, 16'd2, 16'd4, 16'd1, 8, 1, 4, 1'b0, 1'b0, 1'b0};
    rows[1] = '{16'd8, 16'd2, 16'd2, 16'd4, 16'd1, 8, 1, 4, 1'b1, 1'b1, 1'b0};
    rows[2] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd0, 0, 0, 3, 1'b0, 1'b0, 1'b0};
    rows[3] = '{16'd4, 16'd1, 16'd1, 16'd8, 16'd2, 1, 8, 1, 1'b0, 1'b0, 1'b0};
    rows[4] = '{16'd5, 16'd3, 16'd1, 16'd3, 16'd3, 3, 0, 3, 1'b0, 1'b0, 1'b0};
    rows[5] = '{16'd8, 16'd0, 16'd5, 16'd4, 16'd2, 0, 4, 0, 1'b0, 1'b0, 1'b0};
    rows[6] = '{16'd8, 16'd2, 16'd2, 16'd4, 16'd1, 8, 1, 4, 1'b0, 1'b0, 1'b1};
    clear_mon();

    // Reset state, with a beat offered
    mem_valid = 1'b1;
    inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset mem_ready", 80'(mem_ready), 80'(0));
    check("reset busy", 80'(busy), 80'(0));
    check("reset strobes", 80'({layer_para_we, wb_clr, kb_clr, wb_en, kb_en, inst_valid, done}), 80'(0));
    check("reset layer_para", layer_para, 80'(0));
    check("reset inst_o", 80'(inst_o), 80'(0));
    check("reset perf", 80'(perf_stall_cnt), 80'(0));
    mem_valid = 1'b0;

    for (int i = 0; i < 7; i++) run_row(rows[i], $sformatf("row%0d", i));

    // Abort during weight load after 3 beats
    clear_mon();
    @(posedge clk); #1;
    layer_para_i = {16'd1, 16'd4, 16'd2, 16'd2, 16'd8};
    start = 1'b1;
    mem_valid = 1'b1;
    inst_ready = 1'b1;
    beats = 0;
    for (int n = 0; n < 50 && beats < 3; n++) begin
      @(negedge clk);
      if (wb_en) beats++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("abort beats_before", 80'(beats), 80'(3));
    abort = 1'b1;
    @(negedge clk);
    check("abort mem_ready", 80'(mem_ready), 80'(0));
    check("abort wb_en", 80'(wb_en), 80'(0));
    check("abort busy_in_cycle", 80'(busy), 80'(1));
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort busy_after", 80'(busy), 80'(0));
    check("abort clr_pulse", 80'({wb_clr, kb_clr}), 80'(2'b11));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort clr_ends", 80'({wb_clr, kb_clr}), 80'(0));
    repeat (5) @(posedge clk);
    #1 mem_valid = 1'b0;
    @(negedge clk);
    check("abort no_done", 80'(done_cnt), 80'(0));
    check("abort wb_total", 80'(wb_cnt), 80'(3));
    run_row(rows[0], "rerun");

    // start together with abort in IDLE is ignored
    last_desc = {rows[0].k, rows[0].c_ker, rows[0].w, rows[0].h, rows[0].c_wei};
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    layer_para_i = 80'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("idle_sa busy", 80'(busy), 80'(0));
    check("idle_sa layer_para", layer_para, last_desc);
    check("idle_sa clr", 80'({wb_clr, kb_clr, layer_para_we}), 80'(0));
`ifdef CONV_SEQ_CTRL_PERF_EN
    check("idle_sa perf", 80'(perf_stall_cnt), 80'(stall_obs));
`else
    check("idle_sa perf", 80'(perf_stall_cnt), 80'(0));
`endif

    // Async reset in the middle of a layer
    @(posedge clk); #1;
    layer_para_i = last_desc;
    start = 1'b1;
    mem_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("midrst busy", 80'(busy), 80'(0));
    check("midrst outputs", 80'({mem_ready, wb_clr, kb_clr, wb_en, kb_en, inst_valid, done}), 80'(0));
    check("midrst layer_para", layer_para, 80'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("midrst no_clr", 80'({wb_clr, kb_clr}), 80'(0));
    check("midrst idle", 80'(busy), 80'(0));
    mem_valid = 1'b0;
    run_row(rows[3], "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
